cve2_wb_queue: RTL and testbench
================================

// Module: cve2_wb_queue
//
// PURPOSE
// - Multi-entry in-order writeback stage; replaces the single-slot writeback register.
// - Holds up to Depth instructions issued from ID/EX, so several loads/stores can be
//   outstanding at once. Retires strictly in order at the head and drives the register
//   file write port.
// - Resolves ID/EX RAW hazards against every queued entry, forwarding or stalling per operand.
//
// PARAMETERS
// - Depth  default 2  queue entries, >=1. Need not be a power of two.
//                     Depth=1 matches the legacy single-slot writeback timing.
// - CntW   derived    $clog2(Depth+1); width of occupancy and count outputs.
//
// PORTS
// - clk_i                            in   1      clock
// - rst_ni                           in   1      async reset, active low
// - en_wb_i                          in   1      ID/EX offers instruction; enqueued when en_wb_i & ready_wb_o
// - instr_type_wb_i                  in   2      wb_instr_type_e: LOAD/STORE/OTHER
// - pc_id_i                          in   32     PC of offered instruction
// - instr_is_compressed_id_i         in   1      offered instruction is compressed
// - instr_perf_count_id_i            in   1      offered instruction counts as retired
// - rf_waddr_id_i                    in   5      destination register
// - rf_wdata_id_i                    in   32     ID/EX result
// - rf_we_id_i                       in   1      ID/EX result writes the RF
// - rf_wdata_lsu_i                   in   32     load data
// - rf_we_lsu_i                      in   1      LSU load write this cycle
// - lsu_resp_valid_i                 in   1      LSU response, always for the head entry
// - lsu_resp_err_i                   in   1      LSU response is an error
// - rf_raddr_a_i, rf_raddr_b_i       in   5      ID operand addresses for hazard check
// - ready_wb_o                       out  1      queue can accept this cycle
// - fwd_valid_a_o, fwd_valid_b_o     out  1      forward data valid for operand
// - fwd_data_a_o, fwd_data_b_o       out  32     forward data
// - stall_a_o, stall_b_o             out  1      operand hazard not forwardable
// - outstanding_load_wb_o            out  1      any valid LOAD entry
// - outstanding_store_wb_o           out  1      any valid STORE entry
// - occupancy_o                      out  CntW   number of valid entries
// - pc_wb_o                          out  32     head PC (0 when empty)
// - rf_waddr_wb_o                    out  5      RF write address
// - rf_wdata_wb_o                    out  32     RF write data
// - rf_we_wb_o                       out  1      RF write enable
// - instr_done_wb_o                  out  1      head retires this cycle
// - perf_instr_ret_wb_o              out  1      retire counted (excludes LSU error)
// - perf_instr_ret_compressed_wb_o   out  1      counted retire was compressed
// - perf_instr_ret_wb_spec_o         out  CntW   valid entries with count bit set
// - perf_instr_ret_compressed_wb_spec_o out CntW valid entries with count and compressed set
//
// BEHAVIOUR
// - Storage: circular buffer. Each entry holds type, we, waddr, wdata, pc, compressed, count.
//   Head/tail pointers wrap from Depth-1 to 0.
// - Occupancy counter: 0..Depth; Depth means full.
// - head_done = occupancy!=0 & (head.type==OTHER | lsu_resp_valid_i).
// - ready_wb_o = (occupancy<Depth) | head_done. Enqueue and retire in the same cycle at full
//   is legal; occupancy is unchanged.
// - Latency: an OTHER entry entering an empty queue retires the next cycle (1 cycle).
//   LOAD/STORE entries retire on the cycle lsu_resp_valid_i is seen at the head.
// - Only the head retires; at most one retire per cycle.
// - RF port:
//   - rf_we_wb_o = (head valid & head.type==OTHER & head.we) | rf_we_lsu_i.
//   - rf_waddr_wb_o = head.waddr.
//   - rf_wdata_wb_o: LSU data when rf_we_lsu_i, else head.wdata.
//   - Both sources active in one cycle is illegal (asserted).
// - Hazard, per operand: find the youngest valid entry with waddr==raddr, raddr!=0, and
//   (we | type==LOAD).
//   - None: fwd_valid=0, stall=0.
//   - Match is LOAD: stall=1.
//   - Otherwise: fwd_valid=1, fwd_data=entry.wdata.
//   - An entry retiring this cycle still matches.
// - Perf:
//   - perf_instr_ret_wb_o = instr_done_wb_o & head.count & ~(lsu_resp_valid_i & lsu_resp_err_i).
//   - perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & head.compressed.
//   - Spec counts are popcounts over valid entries.
// - lsu_resp_valid_i while empty, or while head is OTHER: protocol violation, asserted.
//   The response is ignored; no retire.
// - Reset: pointers, occupancy and all entry fields clear. ready_wb_o=1 and every other
//   output is 0. Asynchronous assertion mid-operation discards all entries immediately.
//
// CONFIGURATION
// - CVE2_WBQ_FWD_EN defined: forwarding as above.
// - CVE2_WBQ_FWD_EN undefined:
//   - fwd_valid_*=0 and fwd_data_*=0.
//   - Any match (load or not) asserts stall_*.
//   - wdata is not used on any forward path; it feeds only the RF port.
//
// TESTING
// - Depth=2: enqueue OTHER x1 we=1 data 0x55 -> next cycle rf_we_wb_o=1, waddr=1,
//   data=0x55, instr_done=1; then occupancy 0.
// - Depth=2: LOAD x3, STORE, OTHER offered back-to-back, no LSU resp -> ready_wb_o=0
//   after 2 enqueues; outstanding_load/store=1.
// - Full queue, lsu_resp_valid_i with en_wb_i the same cycle -> head retires, new entry
//   enqueued, occupancy stays 2.
// - OTHER x5=0xA then OTHER x5=0xB queued, raddr_a=5 -> fwd_valid_a=1, fwd_data_a=0xB
//   (youngest). With FWD undefined -> stall_a=1.
// - LOAD x7 queued, raddr_b=7 -> stall_b=1. raddr_b=0 -> no stall.
// - LSU resp with err at head, count=1 -> instr_done=1, perf_instr_ret_wb_o=0.
//   Reset asserted with 2 entries queued -> occupancy 0, ready 1, all outputs 0.

Source files
------------

// File: rtl/cve2_wb_queue.sv
// cve2_wb_queue
// -----------------------------------------------------------------------------
// Multi-entry, in-order writeback queue. It sits between ID/EX and the register
// file and holds up to Depth issued instructions, so several loads and stores
// can be waiting for their LSU responses at the same time. Only the head entry
// retires, at most one per cycle, and the head drives the RF write port.
// Every queued entry is checked against the two ID operand addresses:
//
//   - a match on a LOAD always stalls;
//   - any other match forwards the queued result (CVE2_WBQ_FWD_EN defined) or
//     stalls (CVE2_WBQ_FWD_EN undefined, the default build).
//
// Parameters
//   Depth  number of queue entries (>= 1, any value). Depth=1 gives the
//          single-slot writeback timing.
//   CntW   derived width of the occupancy and speculative count outputs.
//
// Ports
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   en_wb_i, instr_type_wb_i, pc_id_i,
//   instr_is_compressed_id_i,
//   instr_perf_count_id_i,
//   rf_waddr_id_i, rf_wdata_id_i,
//   rf_we_id_i                         offered instruction (taken on en & ready)
//   rf_wdata_lsu_i, rf_we_lsu_i        load write data / enable
//   lsu_resp_valid_i, lsu_resp_err_i   LSU response, always for the head
//   rf_raddr_a_i, rf_raddr_b_i         ID operand addresses
//   ready_wb_o                         queue accepts an instruction this cycle
//   fwd_valid_*_o, fwd_data_*_o        forwarded operand data
//   stall_*_o                          operand hazard that cannot be forwarded
//   outstanding_load/store_wb_o        any queued LOAD / STORE
//   occupancy_o                        number of valid entries
//   pc_wb_o                            head PC, 0 when empty
//   rf_waddr/wdata/we_wb_o             register file write port
//   instr_done_wb_o                    head retires this cycle
//   perf_instr_ret_*                   retire and speculative retire counts
//
// Configuration macro: CVE2_WBQ_FWD_EN (enables operand forwarding).
// -----------------------------------------------------------------------------
module cve2_wb_queue #(
    parameter int unsigned  Depth = 2,
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            en_wb_i,
    input  logic [1:0]      instr_type_wb_i,
    input  logic [31:0]     pc_id_i,
    input  logic            instr_is_compressed_id_i,
    input  logic            instr_perf_count_id_i,
    input  logic [4:0]      rf_waddr_id_i,
    input  logic [31:0]     rf_wdata_id_i,
    input  logic            rf_we_id_i,
    input  logic [31:0]     rf_wdata_lsu_i,
    input  logic            rf_we_lsu_i,
    input  logic            lsu_resp_valid_i,
    input  logic            lsu_resp_err_i,
    input  logic [4:0]      rf_raddr_a_i,
    input  logic [4:0]      rf_raddr_b_i,

    output logic            ready_wb_o,
    output logic            fwd_valid_a_o,
    output logic            fwd_valid_b_o,
    output logic [31:0]     fwd_data_a_o,
    output logic [31:0]     fwd_data_b_o,
    output logic            stall_a_o,
    output logic            stall_b_o,
    output logic            outstanding_load_wb_o,
    output logic            outstanding_store_wb_o,
    output logic [CntW-1:0] occupancy_o,
    output logic [31:0]     pc_wb_o,
    output logic [4:0]      rf_waddr_wb_o,
    output logic [31:0]     rf_wdata_wb_o,
    output logic            rf_we_wb_o,
    output logic            instr_done_wb_o,
    output logic            perf_instr_ret_wb_o,
    output logic            perf_instr_ret_compressed_wb_o,
    output logic [CntW-1:0] perf_instr_ret_wb_spec_o,
    output logic [CntW-1:0] perf_instr_ret_compressed_wb_spec_o
);

    typedef enum logic [1:0] {
        WB_INSTR_LOAD  = 2'b00,
        WB_INSTR_STORE = 2'b01,
        WB_INSTR_OTHER = 2'b10
    } wb_instr_type_e;

    // Pointer width is kept at least one bit so Depth=1 still elaborates.
    localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
    localparam logic [PtrW:0]   DepthW  = (PtrW + 1)'(Depth);
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    // ------------------------------------------------------------------
    // Entry storage and queue state
    // ------------------------------------------------------------------
    logic [1:0]      type_reg  [Depth];
    logic            we_reg    [Depth];
    logic [4:0]      waddr_reg [Depth];
    logic [31:0]     wdata_reg [Depth];
    logic [31:0]     pc_reg    [Depth];
    logic            cmp_reg   [Depth];
    logic            cnt_reg   [Depth];

    logic [PtrW-1:0] head_reg, head_next;
    logic [PtrW-1:0] tail_reg, tail_next;
    logic [CntW-1:0] occ_reg,  occ_next;

    logic            head_valid;
    logic            head_other;
    logic            head_done;
    logic            push;
    logic            pop;

    assign head_valid = (occ_reg != '0);
    assign head_other = head_valid && (type_reg[head_reg] == WB_INSTR_OTHER);
    // A response while the head is OTHER is a protocol error; the OTHER entry
    // retires on its own anyway, so the response has no extra effect.
    assign head_done  = head_valid &&
                        ((type_reg[head_reg] == WB_INSTR_OTHER) || lsu_resp_valid_i);

    // Accepting while full is fine when the head leaves in the same cycle.
    assign ready_wb_o = (occ_reg < CntFull) || head_done;
    assign push       = en_wb_i && ready_wb_o;
    assign pop        = head_done;

    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        occ_next  = occ_reg + CntW'(push) - CntW'(pop);
        if (pop) begin
            head_next = (head_reg == PtrLast) ? '0 : head_reg + PtrW'(1);
        end
        if (push) begin
            tail_next = (tail_reg == PtrLast) ? '0 : tail_reg + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_reg <= '0;
            tail_reg <= '0;
            occ_reg  <= '0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
            occ_reg  <= occ_next;
        end
    end

    // Every field is cleared on reset so all head-derived outputs read 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                type_reg[i]  <= '0;
                we_reg[i]    <= 1'b0;
                waddr_reg[i] <= '0;
                wdata_reg[i] <= '0;
                pc_reg[i]    <= '0;
                cmp_reg[i]   <= 1'b0;
                cnt_reg[i]   <= 1'b0;
            end
        end else if (push) begin
            type_reg[tail_reg]  <= instr_type_wb_i;
            we_reg[tail_reg]    <= rf_we_id_i;
            waddr_reg[tail_reg] <= rf_waddr_id_i;
            wdata_reg[tail_reg] <= rf_wdata_id_i;
            pc_reg[tail_reg]    <= pc_id_i;
            cmp_reg[tail_reg]   <= instr_is_compressed_id_i;
            cnt_reg[tail_reg]   <= instr_perf_count_id_i;
        end
    end

    // ------------------------------------------------------------------
    // Age-ordered view: age 0 is the head, age Depth-1 the youngest slot.
    // Slot index = (head + age) mod Depth, done with one conditional subtract
    // so Depth need not be a power of two.
    // ------------------------------------------------------------------
    logic [PtrW-1:0] age_idx [Depth];
    logic [Depth-1:0] age_vld;
    logic [Depth-1:0] age_load;
    logic [Depth-1:0] vld_store;
    logic [Depth-1:0] match_a;
    logic [Depth-1:0] match_b;
    logic [Depth-1:0] spec_cnt_vec;
    logic [Depth-1:0] spec_cmp_vec;

    genvar gi;
    generate
        for (gi = 0; gi < Depth; gi++) begin : g_age
            logic [PtrW:0] slot_sum;
            logic          writes_rf;

            assign slot_sum     = {1'b0, head_reg} + (PtrW + 1)'(gi);
            assign age_idx[gi]  = (slot_sum >= DepthW) ? PtrW'(slot_sum - DepthW)
                                                       : PtrW'(slot_sum);
            assign age_vld[gi]  = (CntW'(gi) < occ_reg);
            assign age_load[gi] = age_vld[gi] &&
                                  (type_reg[age_idx[gi]] == WB_INSTR_LOAD);
            assign vld_store[gi] = age_vld[gi] &&
                                   (type_reg[age_idx[gi]] == WB_INSTR_STORE);

            // Loads produce a register value later even though rf_we was 0
            // at issue, so they count as writers for hazard purposes.
            assign writes_rf    = we_reg[age_idx[gi]] || age_load[gi];
            assign match_a[gi]  = age_vld[gi] && writes_rf && (rf_raddr_a_i != 5'd0) &&
                                  (waddr_reg[age_idx[gi]] == rf_raddr_a_i);
            assign match_b[gi]  = age_vld[gi] && writes_rf && (rf_raddr_b_i != 5'd0) &&
                                  (waddr_reg[age_idx[gi]] == rf_raddr_b_i);

            assign spec_cnt_vec[gi] = age_vld[gi] && cnt_reg[age_idx[gi]];
            assign spec_cmp_vec[gi] = age_vld[gi] && cnt_reg[age_idx[gi]] &&
                                      cmp_reg[age_idx[gi]];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Hazard resolution: scanning oldest to youngest and letting later hits
    // overwrite earlier ones leaves the youngest matching entry selected.
    // ------------------------------------------------------------------
    logic hit_a, hit_b;
`ifdef CVE2_WBQ_FWD_EN
    logic        hit_load_a, hit_load_b;
    logic [31:0] hit_data_a, hit_data_b;
`endif

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
`ifdef CVE2_WBQ_FWD_EN
        hit_load_a = 1'b0;
        hit_load_b = 1'b0;
        hit_data_a = '0;
        hit_data_b = '0;
`endif
        for (int k = 0; k < Depth; k++) begin
            if (match_a[k]) begin
                hit_a = 1'b1;
`ifdef CVE2_WBQ_FWD_EN
                hit_load_a = age_load[k];
                hit_data_a = wdata_reg[age_idx[k]];
`endif
            end
            if (match_b[k]) begin
                hit_b = 1'b1;
`ifdef CVE2_WBQ_FWD_EN
                hit_load_b = age_load[k];
                hit_data_b = wdata_reg[age_idx[k]];
`endif
            end
        end
    end

`ifdef CVE2_WBQ_FWD_EN
    assign stall_a_o     = hit_a && hit_load_a;
    assign stall_b_o     = hit_b && hit_load_b;
    assign fwd_valid_a_o = hit_a && !hit_load_a;
    assign fwd_valid_b_o = hit_b && !hit_load_b;
    assign fwd_data_a_o  = fwd_valid_a_o ? hit_data_a : 32'd0;
    assign fwd_data_b_o  = fwd_valid_b_o ? hit_data_b : 32'd0;
`else
    // Without forwarding the queued result only ever reaches the RF port,
    // so any match must wait for the entry to retire.
    assign stall_a_o     = hit_a;
    assign stall_b_o     = hit_b;
    assign fwd_valid_a_o = 1'b0;
    assign fwd_valid_b_o = 1'b0;
    assign fwd_data_a_o  = 32'd0;
    assign fwd_data_b_o  = 32'd0;
`endif

    // ------------------------------------------------------------------
    // Status and performance counts
    // ------------------------------------------------------------------
    logic [CntW-1:0] spec_cnt_sum;
    logic [CntW-1:0] spec_cmp_sum;

    always_comb begin
        spec_cnt_sum = '0;
        spec_cmp_sum = '0;
        for (int k = 0; k < Depth; k++) begin
            spec_cnt_sum = spec_cnt_sum + CntW'(spec_cnt_vec[k]);
            spec_cmp_sum = spec_cmp_sum + CntW'(spec_cmp_vec[k]);
        end
    end

    assign perf_instr_ret_wb_spec_o            = spec_cnt_sum;
    assign perf_instr_ret_compressed_wb_spec_o = spec_cmp_sum;

    assign outstanding_load_wb_o  = |age_load;
    assign outstanding_store_wb_o = |vld_store;
    assign occupancy_o            = occ_reg;

    // ------------------------------------------------------------------
    // Retire / register file port
    // ------------------------------------------------------------------
    assign instr_done_wb_o = head_done;
    assign pc_wb_o         = head_valid ? pc_reg[head_reg] : 32'd0;
    assign rf_waddr_wb_o   = waddr_reg[head_reg];
    assign rf_we_wb_o      = (head_other && we_reg[head_reg]) || rf_we_lsu_i;
    assign rf_wdata_wb_o   = rf_we_lsu_i ? rf_wdata_lsu_i : wdata_reg[head_reg];

    // An errored LSU response still retires the head but is not counted.
    assign perf_instr_ret_wb_o = head_done && cnt_reg[head_reg] &&
                                 !(lsu_resp_valid_i && lsu_resp_err_i);
    assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o && cmp_reg[head_reg];

`ifndef SYNTHESIS
    // The RF port has a single write; LSU and queued OTHER results must not collide.
    a_rf_single_source : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rf_we_lsu_i && head_other && we_reg[head_reg]));

    // LSU responses always belong to a LOAD/STORE at the head.
    a_lsu_resp_for_head : assert property (@(posedge clk_i) disable iff (!rst_ni)
        lsu_resp_valid_i |-> (head_valid && !head_other));
`endif

endmodule

// File: tb/tb_cve2_wb_queue.sv
// Directed bench for cve2_wb_queue (Depth=2). A scoreboard queue holds the
// expected retire order; entries are pushed when the bench offers an
// instruction it expects to be accepted and popped when the DUT retires.
module tb_cve2_wb_queue;

    localparam logic [1:0] T_LOAD  = 2'b00;
    localparam logic [1:0] T_STORE = 2'b01;
    localparam logic [1:0] T_OTHER = 2'b10;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_wb_i;
    logic [1:0]  instr_type_wb_i;
    logic [31:0] pc_id_i;
    logic        instr_is_compressed_id_i;
    logic        instr_perf_count_id_i;
    logic [4:0]  rf_waddr_id_i;
    logic [31:0] rf_wdata_id_i;
    logic        rf_we_id_i;
    logic [31:0] rf_wdata_lsu_i;
    logic        rf_we_lsu_i;
    logic        lsu_resp_valid_i;
    logic        lsu_resp_err_i;
    logic [4:0]  rf_raddr_a_i;
    logic [4:0]  rf_raddr_b_i;

    logic        ready_wb_o;
    logic        fwd_valid_a_o, fwd_valid_b_o;
    logic [31:0] fwd_data_a_o, fwd_data_b_o;
    logic        stall_a_o, stall_b_o;
    logic        outstanding_load_wb_o, outstanding_store_wb_o;
    logic [1:0]  occupancy_o;
    logic [31:0] pc_wb_o;
    logic [4:0]  rf_waddr_wb_o;
    logic [31:0] rf_wdata_wb_o;
    logic        rf_we_wb_o;
    logic        instr_done_wb_o;
    logic        perf_instr_ret_wb_o;
    logic        perf_instr_ret_compressed_wb_o;
    logic [1:0]  perf_instr_ret_wb_spec_o;
    logic [1:0]  perf_instr_ret_compressed_wb_spec_o;

    cve2_wb_queue #(.Depth(2)) dut (
        .clk_i                               (clk_i),
        .rst_ni                              (rst_ni),
        .en_wb_i                             (en_wb_i),
        .instr_type_wb_i                     (instr_type_wb_i),
        .pc_id_i                             (pc_id_i),
        .instr_is_compressed_id_i            (instr_is_compressed_id_i),
        .instr_perf_count_id_i               (instr_perf_count_id_i),
        .rf_waddr_id_i                       (rf_waddr_id_i),
        .rf_wdata_id_i                       (rf_wdata_id_i),
        .rf_we_id_i                          (rf_we_id_i),
        .rf_wdata_lsu_i                      (rf_wdata_lsu_i),
        .rf_we_lsu_i                         (rf_we_lsu_i),
        .lsu_resp_valid_i                    (lsu_resp_valid_i),
        .lsu_resp_err_i                      (lsu_resp_err_i),
        .rf_raddr_a_i                        (rf_raddr_a_i),
        .rf_raddr_b_i                        (rf_raddr_b_i),
        .ready_wb_o                          (ready_wb_o),
        .fwd_valid_a_o                       (fwd_valid_a_o),
        .fwd_valid_b_o                       (fwd_valid_b_o),
        .fwd_data_a_o                        (fwd_data_a_o),
        .fwd_data_b_o                        (fwd_data_b_o),
        .stall_a_o                           (stall_a_o),
        .stall_b_o                           (stall_b_o),
        .outstanding_load_wb_o               (outstanding_load_wb_o),
        .outstanding_store_wb_o              (outstanding_store_wb_o),
        .occupancy_o                         (occupancy_o),
        .pc_wb_o                             (pc_wb_o),
        .rf_waddr_wb_o                       (rf_waddr_wb_o),
        .rf_wdata_wb_o                       (rf_wdata_wb_o),
        .rf_we_wb_o                          (rf_we_wb_o),
        .instr_done_wb_o                     (instr_done_wb_o),
        .perf_instr_ret_wb_o                 (perf_instr_ret_wb_o),
        .perf_instr_ret_compressed_wb_o      (perf_instr_ret_compressed_wb_o),
        .perf_instr_ret_wb_spec_o            (perf_instr_ret_wb_spec_o),
        .perf_instr_ret_compressed_wb_spec_o (perf_instr_ret_compressed_wb_spec_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [1:0]  ty;
        logic        we;
        logic [31:0] data;
        logic        cnt;
        logic        cmp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        en_wb_i = 0; instr_type_wb_i = T_OTHER; pc_id_i = 0;
        instr_is_compressed_id_i = 0; instr_perf_count_id_i = 0;
        rf_waddr_id_i = 0; rf_wdata_id_i = 0; rf_we_id_i = 0;
        rf_wdata_lsu_i = 0; rf_we_lsu_i = 0;
        lsu_resp_valid_i = 0; lsu_resp_err_i = 0;
        rf_raddr_a_i = 0; rf_raddr_b_i = 0;
    endtask

    task automatic offer(input logic [1:0] ty, input logic [4:0] wa, input logic [31:0] wd,
                         input logic we, input logic [31:0] pc, input logic cmp, input logic cnt);
        en_wb_i = 1; instr_type_wb_i = ty; rf_waddr_id_i = wa; rf_wdata_id_i = wd;
        rf_we_id_i = we; pc_id_i = pc; instr_is_compressed_id_i = cmp;
        instr_perf_count_id_i = cnt;
    endtask

    // Called at the sampling point; the expected ready comes from the bench's plan.
    task automatic expect_ready(input logic exp);
        exp_t e;
        chk("ready", ready_wb_o, exp);
        if (exp) begin
            e.pc = pc_id_i; e.waddr = rf_waddr_id_i; e.ty = instr_type_wb_i;
            e.we = rf_we_id_i; e.data = rf_wdata_id_i;
            e.cnt = instr_perf_count_id_i; e.cmp = instr_is_compressed_id_i;
            sb.push_back(e);
        end
    endtask

    task automatic hazard_a(input logic [31:0] data);
`ifdef CVE2_WBQ_FWD_EN
        chk("fwd_valid_a", fwd_valid_a_o, 1'b1);
        chk("fwd_data_a", fwd_data_a_o, data);
        chk("stall_a", stall_a_o, 1'b0);
`else
        chk("stall_a", stall_a_o, 1'b1);
        chk("fwd_valid_a", fwd_valid_a_o, 1'b0);
        chk("fwd_data_a", fwd_data_a_o, 32'd0);
        if (data == 32'hFFFF_FFFF) $display("note: unexpected hazard data");
`endif
    endtask

    // Retire monitor: compares each retire against the oldest expected entry.
    always @(negedge clk_i) begin
        if (rst_ni && instr_done_wb_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL sb_pop: observed retire pc %0h expected none", pc_wb_o);
            end else begin
                logic perf;
                mon_e = sb.pop_front();
                perf  = mon_e.cnt & ~(lsu_resp_valid_i & lsu_resp_err_i);
                $display("retire pc=%0h waddr=%0d we=%0b wdata=%0h perf=%0b",
                         pc_wb_o, rf_waddr_wb_o, rf_we_wb_o, rf_wdata_wb_o, perf_instr_ret_wb_o);
                chk("ret_pc", pc_wb_o, mon_e.pc);
                chk("ret_waddr", rf_waddr_wb_o, mon_e.waddr);
                if (mon_e.ty == T_OTHER) begin
                    chk("ret_we", rf_we_wb_o, mon_e.we);
                    chk("ret_wdata", rf_wdata_wb_o, mon_e.data);
                end
                chk("ret_perf", perf_instr_ret_wb_o, perf);
                chk("ret_perf_c", perf_instr_ret_compressed_wb_o, perf & mon_e.cmp);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst_ni = 0;
        @(negedge clk_i);
        // Reset state
        chk("rst_ready", ready_wb_o, 1'b1);
        chk("rst_occ", occupancy_o, 2'd0);
        chk("rst_we", rf_we_wb_o, 1'b0);
        chk("rst_pc", pc_wb_o, 32'd0);
        chk("rst_done", instr_done_wb_o, 1'b0);
        chk("rst_ld", outstanding_load_wb_o, 1'b0);
        rst_ni = 1;
        tick();

        // OTHER x1 = 0x55: retires one cycle after entering
        offer(T_OTHER, 5'd1, 32'h55, 1'b1, 32'h100, 1'b1, 1'b1);
        @(negedge clk_i); expect_ready(1'b1);
        tick(); idle();
        @(negedge clk_i);
        chk("t1_occ", occupancy_o, 2'd1);
        chk("t1_we", rf_we_wb_o, 1'b1);
        chk("t1_done", instr_done_wb_o, 1'b1);
        tick();
        @(negedge clk_i);
        chk("t1_occ_after", occupancy_o, 2'd0);
        chk("t1_done_after", instr_done_wb_o, 1'b0);
        tick();

        // LOAD x3, STORE x4, OTHER x6 back-to-back with no LSU response
        offer(T_LOAD, 5'd3, 32'h0, 1'b0, 32'h200, 1'b0, 1'b1);
        @(negedge clk_i); expect_ready(1'b1);
        tick();
        offer(T_STORE, 5'd4, 32'h0, 1'b0, 32'h204, 1'b1, 1'b1);
        @(negedge clk_i); expect_ready(1'b1);
        tick();
        offer(T_OTHER, 5'd6, 32'h66, 1'b1, 32'h208, 1'b0, 1'b1);
        rf_raddr_a_i = 5'd4; rf_raddr_b_i = 5'd3;
        @(negedge clk_i); expect_ready(1'b0);
        chk("t2_occ", occupancy_o, 2'd2);
        chk("t2_out_ld", outstanding_load_wb_o, 1'b1);
        chk("t2_out_st", outstanding_store_wb_o, 1'b1);
        chk("t2_stall_b_load", stall_b_o, 1'b1);
        chk("t2_stall_a_store", stall_a_o, 1'b0);
        chk("t2_spec", perf_instr_ret_wb_spec_o, 2'd2);
        chk("t2_spec_c", perf_instr_ret_compressed_wb_spec_o, 2'd1);
        tick();

        // Full queue: load response and enqueue in the same cycle
        rf_raddr_a_i = 0; rf_raddr_b_i = 0;
        lsu_resp_valid_i = 1; rf_we_lsu_i = 1; rf_wdata_lsu_i = 32'hDEAD;
        @(negedge clk_i); expect_ready(1'b1);
        chk("t3_we", rf_we_wb_o, 1'b1);
        chk("t3_wdata", rf_wdata_wb_o, 32'hDEAD);
        tick(); idle();

        // STORE head gets an error response; OTHER x6 queued behind it
        lsu_resp_valid_i = 1; lsu_resp_err_i = 1; rf_raddr_a_i = 5'd6;
        @(negedge clk_i);
        chk("t3_occ", occupancy_o, 2'd2);
        chk("t5_out_ld", outstanding_load_wb_o, 1'b0);
        chk("t5_done", instr_done_wb_o, 1'b1);
        chk("t5_perf_err", perf_instr_ret_wb_o, 1'b0);
        hazard_a(32'h66);
        tick(); idle();
        @(negedge clk_i);
        tick();

        // LOAD x0 head, then OTHER x5=0xA and x5=0xB
        offer(T_LOAD, 5'd0, 32'h0, 1'b0, 32'h300, 1'b0, 1'b1);
        @(negedge clk_i); expect_ready(1'b1);
        tick();
        offer(T_OTHER, 5'd5, 32'hA, 1'b1, 32'h304, 1'b0, 1'b1);
        rf_raddr_b_i = 5'd0;
        @(negedge clk_i); expect_ready(1'b1);
        chk("t4_stall_b_x0", stall_b_o, 1'b0);
        tick();
        offer(T_OTHER, 5'd5, 32'hB, 1'b1, 32'h308, 1'b1, 1'b1);
        lsu_resp_valid_i = 1; rf_we_lsu_i = 1; rf_wdata_lsu_i = 32'h77; rf_raddr_a_i = 5'd5;
        @(negedge clk_i); expect_ready(1'b1);
        hazard_a(32'hA);
        tick(); idle(); rf_raddr_a_i = 5'd5;
        @(negedge clk_i);
        chk("t4_occ", occupancy_o, 2'd2);
        hazard_a(32'hB);
        tick(); idle(); rf_raddr_a_i = 5'd5;
        @(negedge clk_i);
        hazard_a(32'hB);
        tick(); idle();

        // Asynchronous reset with two entries queued
        offer(T_LOAD, 5'd2, 32'h0, 1'b0, 32'h400, 1'b0, 1'b1);
        @(negedge clk_i); expect_ready(1'b1);
        tick();
        offer(T_STORE, 5'd3, 32'h0, 1'b0, 32'h404, 1'b0, 1'b1);
        @(negedge clk_i); expect_ready(1'b1);
        tick(); idle();
        @(negedge clk_i);
        chk("t6_occ_pre", occupancy_o, 2'd2);
        #2 rst_ni = 0;
        #1;
        sb.delete();
        chk("t6_occ", occupancy_o, 2'd0);
        chk("t6_ready", ready_wb_o, 1'b1);
        chk("t6_ld", outstanding_load_wb_o, 1'b0);
        chk("t6_st", outstanding_store_wb_o, 1'b0);
        chk("t6_pc", pc_wb_o, 32'd0);
        chk("t6_waddr", rf_waddr_wb_o, 32'd0);
        chk("t6_spec", perf_instr_ret_wb_spec_o, 2'd0);
        @(negedge clk_i);
        rst_ni = 1;
        tick();
        @(negedge clk_i);
        chk("t6_occ_post", occupancy_o, 2'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
